// File: rtl/input_skew_feeder_if.sv
// Row/PE bus bundle for the input skew feeder.
//   i_row_data / i_row_vld / o_row_rdy : row handshake from the ping-pong buffer read side
//   o_pe_data / o_pe_vld               : diagonally skewed lanes toward the PE array
// slave  : the feeder's view (accepts rows, drives PE lanes)
// master : the upstream/observer view (drives rows, watches PE lanes)
interface input_skew_feeder_if #(
   parameter int LANES  = 4,
   parameter int DATA_W = 8
);
   logic [LANES*DATA_W-1:0] i_row_data;
   logic                    i_row_vld;
   logic                    o_row_rdy;
   logic [LANES*DATA_W-1:0] o_pe_data;
   logic [LANES-1:0]        o_pe_vld;

   modport slave (
      input  i_row_data,
      input  i_row_vld,
      output o_row_rdy,
      output o_pe_data,
      output o_pe_vld
   );

   modport master (
      output i_row_data,
      output i_row_vld,
      input  o_row_rdy,
      input  o_pe_data,
      input  o_pe_vld
   );
endinterface

// File: rtl/input_skew_feeder.sv
// Input skew feeder: re-times one row of LANES elements per beat into the
// diagonal skew the systolic PE array expects (lane k delayed k cycles relative
// to lane 0), counts ROWS rows per tile, drains the skew pipeline and then
// pulses a ping-pong switch request back to the buffer.
// Ports:
//   dout_clk          : clock, rising edge
//   rst               : synchronous active-high reset (wins over en)
//   en                : global enable, 0 freezes everything and masks valids
//   bus               : row handshake in / skewed PE lanes out (slave modport)
//   o_switch_pingpong : one-cycle pulse at tile completion
//   o_busy            : high whenever a tile is in progress or draining
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no rows of the current tile accepted yet, ready for a row
// FEED  | 1..ROWS-1 rows accepted, still ready for rows
// DRAIN | tile complete, flushing bubbles until the last lane empties
module input_skew_feeder #(
   parameter int LANES  = 4,
   parameter int DATA_W = 8,
   parameter int ROWS   = 8
) (
   input  logic                 dout_clk,
   input  logic                 rst,
   input  logic                 en,
   input_skew_feeder_if.slave   bus,
   output logic                 o_switch_pingpong,
   output logic                 o_busy
);

   localparam int RW = $clog2(ROWS + 1);
   localparam int DW = (LANES > 1) ? $clog2(LANES) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FEED  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t          state, state_nxt;
   logic [RW-1:0]   row_cnt, row_cnt_nxt;
   logic [DW-1:0]   drain_cnt, drain_cnt_nxt;
   logic            pulse_q, pulse_nxt;
   logic            row_rdy;
   logic            accept;
   logic [LANES-1:0] lane_vld;

   assign row_rdy       = en & ~rst & (state != DRAIN);
   assign accept        = bus.i_row_vld & row_rdy;
   assign bus.o_row_rdy = row_rdy;

   // Valids are masked while stalled so a frozen element is never consumed twice;
   // data simply holds.
   assign bus.o_pe_vld     = lane_vld & {LANES{en}};
   assign o_switch_pingpong = pulse_q & en;
   assign o_busy            = (state != IDLE);

   always_ff @(posedge dout_clk) begin
      if (rst) begin
         state     <= IDLE;
         row_cnt   <= '0;
         drain_cnt <= '0;
         pulse_q   <= 1'b0;
      end else if (en) begin
         state     <= state_nxt;
         row_cnt   <= row_cnt_nxt;
         drain_cnt <= drain_cnt_nxt;
         pulse_q   <= pulse_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      row_cnt_nxt   = row_cnt;
      drain_cnt_nxt = drain_cnt;
      pulse_nxt     = 1'b0;
      case (state)
         IDLE, FEED: begin
            // row_cnt is 0 in IDLE, so the same compare also covers ROWS == 1.
            if (accept) begin
               if (row_cnt == RW'(ROWS - 1)) begin
                  state_nxt   = DRAIN;
                  row_cnt_nxt = '0;
               end else begin
                  state_nxt   = FEED;
                  row_cnt_nxt = row_cnt + 1'b1;
               end
            end
         end
         DRAIN: begin
            // At LANES-1 the last lane's final element is on the outputs.
            if (drain_cnt == DW'(LANES - 1)) begin
               state_nxt     = IDLE;
               drain_cnt_nxt = '0;
               pulse_nxt     = 1'b1;
            end else begin
               drain_cnt_nxt = drain_cnt + 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Lane k is a (k+1)-deep shift register of {data, vld}; the top stage drives the output.
   for (genvar k = 0; k < LANES; k++) begin : g_lane
      logic [DATA_W-1:0]         stage_in;
      logic [(k+1)*DATA_W-1:0]   d_sr;
      logic [k:0]                v_sr;

      assign stage_in = accept ? bus.i_row_data[k*DATA_W +: DATA_W] : '0;

      if (k == 0) begin : g_one
         always_ff @(posedge dout_clk) begin
            if (rst) begin
               d_sr <= '0;
               v_sr <= '0;
            end else if (en) begin
               d_sr <= stage_in;
               v_sr <= accept;
            end
         end
      end else begin : g_multi
         always_ff @(posedge dout_clk) begin
            if (rst) begin
               d_sr <= '0;
               v_sr <= '0;
            end else if (en) begin
               d_sr <= {d_sr[k*DATA_W-1:0], stage_in};
               v_sr <= {v_sr[k-1:0], accept};
            end
         end
      end

      assign bus.o_pe_data[k*DATA_W +: DATA_W] = d_sr[k*DATA_W +: DATA_W];
      assign lane_vld[k]                       = v_sr[k];
   end

endmodule

// File: tb/tb_input_skew_feeder.sv
// Bench for input_skew_feeder: directed scenarios plus a random tail, every
// cycle compared against a history-based reference model.
module tb_input_skew_feeder;

   localparam int LANES  = 4;
   localparam int DATA_W = 8;
   localparam int ROWS   = 8;
   localparam int W      = LANES * DATA_W;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;
   logic en;
   logic sw;
   logic busy;

   input_skew_feeder_if #(.LANES(LANES), .DATA_W(DATA_W)) bus ();

   input_skew_feeder #(.LANES(LANES), .DATA_W(DATA_W), .ROWS(ROWS)) dut (
      .dout_clk          (clk),
      .rst               (rst),
      .en                (en),
      .bus               (bus),
      .o_switch_pingpong (sw),
      .o_busy            (busy)
   );

   // Reference model: a history of what entered the array on each enabled edge
   // (most recent last); lane k shows the entry from k+1 enabled edges ago.
   typedef struct packed {
      logic         v;
      logic [W-1:0] d;
   } slot_t;

   slot_t hist[$];
   int    rows_in_tile;
   int    drain_edges;
   bit    draining;
   bit    pulse_pend;
   bit    mvalid = 1'b0;

   int errors = 0;
   int checks = 0;
   int cyc_n  = 0;
   int pulse_cyc = -1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      slot_t z;
      z = '0;
      hist.delete();
      for (int i = 0; i < LANES; i++) hist.push_back(z);
      rows_in_tile = 0;
      drain_edges  = 0;
      draining     = 1'b0;
      pulse_pend   = 1'b0;
   endtask

   task automatic step(input bit r, input bit e, input bit v, input logic [W-1:0] d);
      bit               rdy_e;
      bit               acc;
      bit               pnext;
      slot_t            s;
      logic [W-1:0]     exp_d;
      logic [LANES-1:0] exp_v;
      rst = r;
      en  = e;
      bus.i_row_vld  = v;
      bus.i_row_data = d;
      #1;
      rdy_e = 1'b0;
      if (mvalid) begin
         rdy_e = e & ~r & ~draining;
         for (int k = 0; k < LANES; k++) begin
            s = hist[hist.size() - 1 - k];
            exp_d[k*DATA_W +: DATA_W] = s.d[k*DATA_W +: DATA_W];
            exp_v[k] = s.v & e;
         end
         chk("row_rdy", {63'd0, bus.o_row_rdy}, {63'd0, rdy_e});
         chk("pe_data", {32'd0, bus.o_pe_data}, {32'd0, exp_d});
         chk("pe_vld",  {60'd0, bus.o_pe_vld}, {60'd0, exp_v});
         chk("switch",  {63'd0, sw}, {63'd0, pulse_pend & e});
         chk("busy",    {63'd0, busy}, {63'd0, (rows_in_tile > 0) || draining});
      end
      if (sw === 1'b1) pulse_cyc = cyc_n;
      acc = v & rdy_e;
      @(posedge clk);
      if (r) begin
         model_reset();
         mvalid = 1'b1;
      end else if (e && mvalid) begin
         s.v = acc;
         s.d = acc ? d : '0;
         hist.push_back(s);
         void'(hist.pop_front());
         pnext = 1'b0;
         if (draining) begin
            drain_edges++;
            if (drain_edges == LANES) begin
               draining    = 1'b0;
               drain_edges = 0;
               pnext       = 1'b1;
            end
         end else if (acc) begin
            rows_in_tile++;
            if (rows_in_tile == ROWS) begin
               draining     = 1'b1;
               rows_in_tile = 0;
            end
         end
         pulse_pend = pnext;
      end
      cyc_n++;
      #1;
   endtask

   function automatic logic [W-1:0] tile_row(input int r);
      logic [W-1:0] x;
      for (int k = 0; k < LANES; k++) x[k*DATA_W +: DATA_W] = DATA_W'(r * LANES + k);
      return x;
   endfunction

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, W'($urandom));
   endtask

   task automatic full_tile(input string tag);
      int start;
      pulse_cyc = -1;
      start = cyc_n;
      for (int r = 0; r < ROWS; r++) step(1'b0, 1'b1, 1'b1, tile_row(r));
      idle(LANES + 3);
      chk(tag, 64'(pulse_cyc - start), 64'(ROWS + LANES));
   endtask

   initial begin
      int acc_n;
      int pat_i;
      bit pat [5];
      pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

      // Reset with enable and valid asserted.
      for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1, W'($urandom));
      idle(2);

      // Full back-to-back tile: pulse exactly ROWS+LANES cycles after first accept.
      full_tile("pulse_cycle_full");

      // Bubble pattern until ROWS rows are in.
      acc_n = 0;
      pat_i = 0;
      while (acc_n < ROWS) begin
         step(1'b0, 1'b1, pat[pat_i], W'($urandom));
         if (pat[pat_i]) acc_n++;
         pat_i = (pat_i + 1) % 5;
      end
      idle(LANES + 3);

      // Stall for 3 cycles after row 4; upstream keeps offering rows meanwhile.
      for (int r = 0; r < 4; r++) step(1'b0, 1'b1, 1'b1, tile_row(r));
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, W'($urandom));
      for (int r = 4; r < ROWS; r++) step(1'b0, 1'b1, 1'b1, tile_row(r));
      idle(LANES + 3);

      // Reset after 5 accepts: no pulse, then a clean full tile.
      pulse_cyc = -1;
      for (int r = 0; r < 5; r++) step(1'b0, 1'b1, 1'b1, tile_row(r));
      step(1'b1, 1'b1, 1'b1, W'($urandom));
      idle(LANES + 3);
      chk("no_pulse_after_reset", 64'(pulse_cyc), 64'(-1));
      full_tile("pulse_cycle_after_reset");

      // Valid held high with fresh data through DRAIN: nothing taken while draining.
      for (int i = 0; i < 3 * (ROWS + LANES); i++) step(1'b0, 1'b1, 1'b1, W'($urandom));
      idle(LANES + 3);

      // Random tail: enables, valids and occasional resets.
      for (int i = 0; i < 400; i++)
         step($urandom_range(0, 80) == 0, $urandom_range(0, 6) != 0,
              $urandom_range(0, 2) != 0, W'($urandom));
      idle(LANES + 3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/input_skew_feeder.md
Name: input_skew_feeder

Overview:
- Sits directly downstream of the input ping-pong pre-data buffer, in the dout_clk domain.
- Accepts one row of LANES bytes per beat from the buffer read side and re-times the lanes into the diagonal (systolic) skew the PE array needs: lane k is delayed k cycles relative to lane 0.
- Counts ROWS rows per tile, drains the skew pipeline, then pulses a ping-pong switch request back to the buffer.

Parameters:
- LANES, 4, number of PE array input lanes (skew depth = LANES-1).
- DATA_W, 8, bits per lane element.
- ROWS, 8, rows per tile before a ping-pong switch is requested.

Ports:
- dout_clk  in  1  single clock; all logic rising-edge.
- rst  in  1  synchronous active-high reset.
- en  in  1  global enable; 0 stalls the block.
- i_row_data  in  LANES*DATA_W  row from buffer; lane k = bits [k*DATA_W +: DATA_W].
- i_row_vld  in  1  row valid.
- o_row_rdy  out  1  block can accept a row this cycle.
- o_pe_data  out  LANES*DATA_W  skewed data to PE array, same lane packing.
- o_pe_vld  out  LANES  per-lane valid, skewed with the data.
- o_switch_pingpong  out  1  one-cycle pulse at tile completion.
- o_busy  out  1  state != IDLE.

Behaviour:
- Reset (rst=1 at an edge; has priority over en): all shift stages cleared to data 0 / vld 0; row_cnt=0; drain_cnt=0; state=IDLE. Outputs o_pe_data=0, o_pe_vld=0, o_switch_pingpong=0, o_busy=0. o_row_rdy is 0 while rst is high.
- Accept: accept = i_row_vld & o_row_rdy, sampled at the rising edge.
- Skew chain: lane k is a (k+1)-deep register chain carrying {data, vld}.
  - On every enabled edge, stage 0 of every lane loads the accepted lane data with vld=1, or 0/vld=0 when there is no accept (bubble).
  - Lane k output appears k+1 cycles after the accept cycle. Lane 0 latency is 1.
- en=0: all chains, counters and state hold. o_pe_data holds. o_pe_vld is forced to 0. o_row_rdy=0. o_switch_pingpong=0. There is no accept regardless of i_row_vld.
- FSM:
  - IDLE: o_row_rdy=en. On accept, row_cnt<=1 and go to FEED; if ROWS==1, go directly to DRAIN.
  - FEED: o_row_rdy=en. Each accept increments row_cnt. The accept that makes row_cnt==ROWS transitions to DRAIN and clears row_cnt.
  - DRAIN: o_row_rdy=0; i_row_vld is ignored. Bubbles keep shifting and drain_cnt increments each enabled cycle. When drain_cnt reaches LANES-1, the tile's last lane-(LANES-1) element is on the outputs. On the next enabled edge: o_switch_pingpong=1 for exactly one cycle, drain_cnt<=0, state<=IDLE.
- Required timing: for back-to-back accepts in cycles 0..ROWS-1:
  - o_pe_vld[k] is high in cycles k+1 .. k+ROWS.
  - o_switch_pingpong is high in cycle ROWS+LANES.
  - o_row_rdy is low in cycles ROWS .. ROWS+LANES-1.
  - o_row_rdy is high again in cycle ROWS+LANES, the same cycle as the pulse.
- Bubbles in FEED (i_row_vld=0) insert zero/vld-0 slots and do not count as rows.
- Arithmetic: row_cnt width = clog2(ROWS+1); drain_cnt width = clog2(LANES). No wrap occurs within a tile; both counters are cleared on the DRAIN exit and on reset.
- Reset mid-tile: partial tile is discarded; no o_switch_pingpong pulse is produced; the next accept starts at row_cnt=1.

Test Plan:
- Reset/idle: hold rst 3 cycles with en=1, i_row_vld=1 -> all outputs 0, o_row_rdy=0. After release, o_row_rdy=1 and o_busy=0.
- Full tile: en=1, 8 back-to-back rows, row r lane k = r*4+k -> lane 3 carries 3,7,...,31 in cycles 4..11. o_switch_pingpong high only in cycle 12. o_row_rdy low in cycles 8..11.
- Bubbles: drive i_row_vld pattern 1,0,1,1,0,... until 8 rows are accepted -> o_pe_vld lanes show matching zero slots (data 0). Switch pulse occurs exactly LANES cycles after the 8th accept + 1.
- Stall: drop en for 3 cycles after row 4 -> o_pe_data frozen, o_pe_vld=0, no accepts. After resume, the lane sequences are identical to the full-tile case shifted by 3 cycles.
- Reset mid-tile: assert rst after 5 accepts -> next cycle outputs are 0 and no switch pulse. A following full tile behaves exactly as in the full-tile scenario.
- Ignore while draining: hold i_row_vld=1 with new data during DRAIN -> nothing accepted. First data of the next tile is the row presented when o_row_rdy returns to 1.
